// File: rtl/freq_div_multi.sv
// -----------------------------------------------------------------------------
// freq_div_multi
//
// Multi-channel, runtime-programmable clock divider. Each of CH channels counts
// system clock cycles up to its divisor DIV and, on terminal count (TC), emits
// a one-cycle O_TICK strobe and toggles its 50 % duty O_CLK output. O_TICK is
// meant as a clock enable for downstream logic; O_CLK is for pins/LEDs only.
//
// Parameters
//   CH       number of channels (1..16)
//   CNT_W    divisor / counter width
//   DIV_RST  divisor loaded into every channel at reset
//   AW       write address width ($clog2(CH), minimum 1)
//
// Ports
//   I_CLK   in   1      system clock, rising edge
//   I_RST   in   1      synchronous active-high reset
//   I_EN    in   CH     per-channel run enable
//   I_WE    in   1      divisor write strobe (one cycle)
//   I_ADDR  in   AW     channel index for the write; indices >= CH are ignored
//   I_DIV   in   CNT_W  divisor value for the write
//   O_CLK   out  CH     per-channel toggle output, period 2*DIV cycles
//   O_TICK  out  CH     per-channel one-cycle pulse every DIV cycles
//
// Build option
//   FREQ_DIV_SHADOW_EN  undefined: a write takes effect immediately and
//                       restarts the channel count.
//                       defined:   a write is held pending and loaded at the
//                       channel's next TC (or on the next edge if the channel
//                       is stopped or disabled), so no period is ever cut short.
// -----------------------------------------------------------------------------
module freq_div_multi #(
    parameter int unsigned      CH      = 4,
    parameter int unsigned      CNT_W   = 32,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(6_000_000),
    parameter int unsigned      AW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic [CH-1:0]    I_EN,
    input  logic             I_WE,
    input  logic [AW-1:0]    I_ADDR,
    input  logic [CNT_W-1:0] I_DIV,
    output logic [CH-1:0]    O_CLK,
    output logic [CH-1:0]    O_TICK
);

    for (genvar g = 0; g < CH; g++) begin : g_ch

        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;

        logic             wr_hit;
        logic             stopped;
        logic             tc;

        // Only indices 0..CH-1 can match, so out-of-range addresses fall through.
        assign wr_hit  = I_WE && (I_ADDR == AW'(g));
        assign stopped = (div_q == '0);
        // DIV-1 is only meaningful when DIV != 0; the stopped term guards the wrap.
        assign tc      = I_EN[g] && !stopped && (cnt_q == (div_q - CNT_W'(1)));

`ifdef FREQ_DIV_SHADOW_EN

        logic [CNT_W-1:0] pend_q, pend_d;
        logic             pend_v_q, pend_v_d;

        always_comb begin
            div_d    = div_q;
            cnt_d    = cnt_q;
            clk_d    = clk_q;
            tick_d   = 1'b0;
            pend_d   = pend_q;
            pend_v_d = pend_v_q;

            if (wr_hit) begin
                pend_d   = I_DIV;
                pend_v_d = 1'b1;
            end

            if (tc) begin
                // The finishing period always ticks; the new divisor governs
                // the next one. A write landing on TC bypasses the pending slot.
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                if (wr_hit) begin
                    div_d    = I_DIV;
                    pend_v_d = 1'b0;
                end else if (pend_v_q) begin
                    div_d    = pend_q;
                    pend_v_d = 1'b0;
                end
            end else if (!stopped && I_EN[g]) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                if (stopped) begin
                    cnt_d = '0;
                end
                // Idle channel: no TC will come, so load the pending divisor
                // now. CNT is cleared so a smaller divisor cannot leave CNT
                // stranded above DIV-1.
                if (pend_v_q && !wr_hit) begin
                    div_d    = pend_q;
                    pend_v_d = 1'b0;
                    cnt_d    = '0;
                end
            end
        end

        always_ff @(posedge I_CLK) begin
            if (I_RST) begin
                div_q    <= DIV_RST;
                cnt_q    <= '0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
                pend_q   <= '0;
                pend_v_q <= 1'b0;
            end else begin
                div_q    <= div_d;
                cnt_q    <= cnt_d;
                clk_q    <= clk_d;
                tick_q   <= tick_d;
                pend_q   <= pend_d;
                pend_v_q <= pend_v_d;
            end
        end

`else

        always_comb begin
            div_d  = div_q;
            cnt_d  = cnt_q;
            clk_d  = clk_q;
            tick_d = 1'b0;

            if (wr_hit) begin
                // Immediate load restarts the period and suppresses any TC on
                // this edge; clearing CNT also covers a divisor lowered below CNT.
                div_d = I_DIV;
                cnt_d = '0;
            end else if (stopped) begin
                cnt_d = '0;
            end else if (I_EN[g]) begin
                if (tc) begin
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge I_CLK) begin
            if (I_RST) begin
                div_q  <= DIV_RST;
                cnt_q  <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                cnt_q  <= cnt_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

`endif

        assign O_CLK[g]  = clk_q;
        assign O_TICK[g] = tick_q;

    end : g_ch

endmodule

// File: tb/tb_freq_div_multi.sv
// -----------------------------------------------------------------------------
// tb_freq_div_multi
//
// Directed bench for freq_div_multi with CH=4, CNT_W=8, DIV_RST=3 and AW
// widened to 3 so that an out-of-range write address (7) can be driven.
// Edges after a reset edge are numbered E1, E2, ...; outputs are sampled 1 time
// unit after each rising edge and inputs are changed at that same point, so
// they are sampled on the following edge.
// -----------------------------------------------------------------------------
module tb_freq_div_multi;

    logic       I_CLK = 1'b0;
    logic       I_RST;
    logic [3:0] I_EN;
    logic       I_WE;
    logic [2:0] I_ADDR;
    logic [7:0] I_DIV;
    logic [3:0] O_CLK;
    logic [3:0] O_TICK;

    int tests = 0;
    int fails = 0;

    freq_div_multi #(
        .CH      (4),
        .CNT_W   (8),
        .DIV_RST (8'd3),
        .AW      (3)
    ) dut (
        .I_CLK  (I_CLK),
        .I_RST  (I_RST),
        .I_EN   (I_EN),
        .I_WE   (I_WE),
        .I_ADDR (I_ADDR),
        .I_DIV  (I_DIV),
        .O_CLK  (O_CLK),
        .O_TICK (O_TICK)
    );

    always #5 I_CLK = ~I_CLK;

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of run, expected $finish before 200000");
        $fatal(1, "bench timeout");
    end

    task automatic cyc();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One-edge reset with every channel enabled; leaves the bench just after
    // the reset edge so the next cyc() is E1.
    task automatic do_reset();
        I_RST = 1'b1;
        I_WE  = 1'b0;
        I_EN  = 4'hF;
        cyc();
        chk("rst1_tick", O_TICK, 4'h0);
        chk("rst1_clk",  O_CLK,  4'h0);
        I_RST = 1'b0;
    endtask

    initial begin
        I_RST  = 1'b1;
        I_EN   = 4'hF;
        I_WE   = 1'b0;
        I_ADDR = '0;
        I_DIV  = '0;

        // ---- Reset state and free run at DIV_RST=3 --------------------------
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_tick", O_TICK, 4'h0);
            chk("rst_clk",  O_CLK,  4'h0);
        end
        I_RST = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("run_tick", O_TICK, (k % 3 == 0) ? 4'hF : 4'h0);
            chk("run_clk",  O_CLK,  ((k / 3) % 2 == 1) ? 4'hF : 4'h0);
        end

        // ---- Disable ch1 at CNT=1 for 5 edges -------------------------------
        do_reset();
        cyc();                                   // E1: CNT=1 everywhere
        I_EN = 4'b1101;
        for (int k = 2; k <= 6; k++) begin
            cyc();
            chk("dis_tick1", O_TICK & 4'b0010, 4'b0000);
            chk("dis_clk1",  O_CLK  & 4'b0010, 4'b0000);
        end
        chk("dis_e6_others", O_TICK, 4'b1101);
        I_EN = 4'hF;
        cyc();                                   // E7: ch1 CNT=2
        chk("reen_e7_tick", O_TICK, 4'b0000);
        cyc();                                   // E8: ch1 TC
        chk("reen_e8_tick", O_TICK, 4'b0010);
        chk("reen_e8_clk",  O_CLK,  4'b0010);

        // ---- ch2 DIV=1 then DIV=0 -------------------------------------------
        do_reset();
        I_WE = 1'b1; I_ADDR = 3'd2; I_DIV = 8'd1;
        cyc();                                   // E1: write sampled
        I_WE = 1'b0;
        chk("d1_e1_tick", O_TICK, 4'b0000);
        cyc();
        chk("d1_e2_tick", O_TICK, 4'b0100);
        chk("d1_e2_clk",  O_CLK,  4'b0100);
        cyc();
        chk("d1_e3_tick", O_TICK, 4'b1111);
        chk("d1_e3_clk",  O_CLK,  4'b1011);
        cyc();
        chk("d1_e4_tick", O_TICK, 4'b0100);
        chk("d1_e4_clk",  O_CLK,  4'b1111);
        I_WE = 1'b1; I_ADDR = 3'd2; I_DIV = 8'd0;
        cyc();                                   // E5: DIV=0 sampled
        I_WE = 1'b0;
        chk("d0_e5_tick", O_TICK, 4'b0000);
        chk("d0_e5_clk",  O_CLK,  4'b1111);
        cyc();
        chk("d0_e6_tick", O_TICK, 4'b1011);
        chk("d0_e6_clk",  O_CLK,  4'b0100);
        cyc();
        cyc();
        chk("d0_e8_tick", O_TICK, 4'b0000);
        cyc();
        chk("d0_e9_tick", O_TICK, 4'b1011);
        chk("d0_e9_clk",  O_CLK,  4'b1111);

        // ---- Out-of-range write address is ignored --------------------------
        do_reset();
        I_WE = 1'b1; I_ADDR = 3'd7; I_DIV = 8'd1;
        cyc();                                   // E1
        I_WE = 1'b0; I_ADDR = 3'd0;
        cyc();
        chk("oor_e2_tick", O_TICK, 4'b0000);
        cyc();
        chk("oor_e3_tick", O_TICK, 4'b1111);
        cyc();
        chk("oor_e4_tick", O_TICK, 4'b0000);

`ifdef FREQ_DIV_SHADOW_EN
        // ---- Shadowed write ch0 DIV=5 at CNT=1 ------------------------------
        do_reset();
        cyc();                                   // E1
        I_WE = 1'b1; I_ADDR = 3'd0; I_DIV = 8'd5;
        cyc();                                   // E2: stored as pending
        I_WE = 1'b0;
        chk("sh_e2_tick", O_TICK, 4'b0000);
        cyc();                                   // E3: old period completes
        chk("sh_e3_tick", O_TICK, 4'b1111);
        chk("sh_e3_clk",  O_CLK,  4'b1111);
        for (int k = 4; k <= 7; k++) begin
            cyc();
            chk("sh_mid_tick", O_TICK, (k == 6) ? 4'b1110 : 4'b0000);
        end
        cyc();                                   // E8: first 5-cycle tick
        chk("sh_e8_tick", O_TICK, 4'b0001);
        chk("sh_e8_clk",  O_CLK,  4'b0000);
        for (int k = 9; k <= 12; k++) begin
            cyc();
            chk("sh_gap_tick", O_TICK, (k % 3 == 0) ? 4'b1110 : 4'b0000);
        end
        I_WE = 1'b1; I_ADDR = 3'd0; I_DIV = 8'd2;
        cyc();                                   // E13: write on TC
        I_WE = 1'b0;
        chk("sh_tcw_e13_tick", O_TICK, 4'b0001);
        chk("sh_tcw_e13_clk",  O_CLK,  4'b0001);
        cyc();
        chk("sh_tcw_e14_tick", O_TICK, 4'b0000);
        cyc();
        chk("sh_tcw_e15_tick", O_TICK, 4'b1111);
`else
        // ---- Immediate write ch0 DIV=5 at CNT=1 -----------------------------
        do_reset();
        cyc();                                   // E1
        I_WE = 1'b1; I_ADDR = 3'd0; I_DIV = 8'd5;
        cyc();                                   // E2: CNT0 cleared
        I_WE = 1'b0;
        chk("im_e2_tick", O_TICK, 4'b0000);
        for (int k = 3; k <= 6; k++) begin
            cyc();
            chk("im_mid_tick", O_TICK, (k % 3 == 0) ? 4'b1110 : 4'b0000);
        end
        cyc();                                   // E7: 5 edges after write
        chk("im_e7_tick", O_TICK, 4'b0001);
        chk("im_e7_clk",  O_CLK,  4'b0001);
        for (int k = 8; k <= 11; k++) cyc();
        cyc();                                   // E12
        chk("im_e12_tick", O_TICK, 4'b1111);

        // ---- Immediate write landing on TC suppresses tick/toggle ----------
        do_reset();
        cyc();
        cyc();                                   // E2
        I_WE = 1'b1; I_ADDR = 3'd1; I_DIV = 8'd2;
        cyc();                                   // E3: TC + write on ch1
        I_WE = 1'b0;
        chk("tcw_e3_tick", O_TICK, 4'b1101);
        chk("tcw_e3_clk",  O_CLK,  4'b1101);
        cyc();
        chk("tcw_e4_tick", O_TICK, 4'b0000);
        cyc();
        chk("tcw_e5_tick", O_TICK, 4'b0010);
        chk("tcw_e5_clk",  O_CLK,  4'b1111);
`endif

        // ---- Reset mid-count together with a write --------------------------
        do_reset();
        for (int k = 1; k <= 3; k++) cyc();
`ifdef FREQ_DIV_SHADOW_EN
        I_WE = 1'b1; I_ADDR = 3'd0; I_DIV = 8'd5;   // pending at E4
`endif
        cyc();                                   // E4: CNT=1, CLK=1
        I_WE = 1'b0;
        chk("mr_e4_clk", O_CLK, 4'b1111);
        I_RST = 1'b1; I_WE = 1'b1; I_ADDR = 3'd0; I_DIV = 8'd5;
        cyc();                                   // E5: reset wins
        I_RST = 1'b0; I_WE = 1'b0;
        chk("mr_e5_tick", O_TICK, 4'b0000);
        chk("mr_e5_clk",  O_CLK,  4'b0000);
        cyc();
        cyc();
        chk("mr_e7_tick", O_TICK, 4'b0000);
        cyc();                                   // E8: DIV_RST after reset
        chk("mr_e8_tick", O_TICK, 4'b1111);
        chk("mr_e8_clk",  O_CLK,  4'b1111);
        cyc();
        cyc();
        cyc();                                   // E11
        chk("mr_e11_tick", O_TICK, 4'b1111);
        chk("mr_e11_clk",  O_CLK,  4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
